approx_add_arbiter: RTL and testbench

Shares one configurable approximate adder (split-carry truncated mode or exact mode) among R requesters. Arbitration is round-robin; each side uses a valid/ready handshake. Every request carries its own precision mode. The block registers each result and tags it with the requester index. It also keeps a global saturating count of dropped carries, which the approximate-compute monitoring path reads.

---
 rtl/approx_add_arbiter.sv | 123 ++++++++++++
 tb/tb_approx_add_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_arbiter.sv
// rtl/approx_add_arbiter.sv - round-robin shared approximate/exact adder with tagged registered result
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   req_valid[R]     per-requester request valid
//   req_ready[R]     per-requester accept (one-hot or zero)
//   req_a/req_b      packed operands, requester i at [i*N +: N]
//   req_approx[R]    per-requester mode: 1 = split-carry approximate, 0 = exact
//   res_valid/ready  result handshake
//   res_sum          registered sum
//   res_id           requester index that produced res_sum
//   res_dropped      carry out of the low K bits was discarded
//   drop_clr         clears drop_count (wins over a same-cycle increment)
//   drop_count       saturating count of dropped carries
module approx_add_arbiter #(
    parameter int N   = 32,
    parameter int K   = 8,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    input  logic [R-1:0]     req_approx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_sum,
    output logic [IDW-1:0]   res_id,
    output logic             res_dropped,
    input  logic             drop_clr,
    output logic [15:0]      drop_count
);

    logic [IDW-1:0] rr_ptr;
    logic [R-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           found;
    logic           can_accept;
    logic           transfer;

    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic           sel_approx;
    logic [N-1:0]   exact_sum;
    logic [K:0]     lo_sum;
    logic [N-K-1:0] hi_sum;
    logic [N-1:0]   next_sum;
    logic           next_dropped;

    assign can_accept = !res_valid || res_ready;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int j = 0; j < R; j++) begin
            idx = (int'(rr_ptr) + j) % R;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

    // Held low while in reset so nothing can be accepted on the reset edge.
    assign req_ready = (can_accept && rst_n) ? grant : '0;
    assign transfer  = |req_ready;

    assign sel_a      = req_a[grant_id*N +: N];
    assign sel_b      = req_b[grant_id*N +: N];
    assign sel_approx = req_approx[grant_id];

    // Both paths are computed; the mode only selects. The upper segment in
    // approximate mode never sees the low carry.
    assign exact_sum = sel_a + sel_b;
    assign lo_sum    = {1'b0, sel_a[K-1:0]} + {1'b0, sel_b[K-1:0]};
    assign hi_sum    = sel_a[N-1:K] + sel_b[N-1:K];

    always_comb begin
        next_sum     = exact_sum;
        next_dropped = 1'b0;
        if (sel_approx) begin
            next_sum     = {hi_sum, lo_sum[K-1:0]};
            next_dropped = lo_sum[K];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_sum     <= '0;
            res_id      <= '0;
            res_dropped <= 1'b0;
            rr_ptr      <= '0;
        end else if (transfer) begin
            res_valid   <= 1'b1;
            res_sum     <= next_sum;
            res_id      <= grant_id;
            res_dropped <= next_dropped;
            rr_ptr      <= (grant_id == IDW'(R-1)) ? '0 : grant_id + 1'b1;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= '0;
        end else if (transfer && next_dropped && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_approx_add_arbiter.sv
// tb/tb_approx_add_arbiter.sv - directed self-checking bench for approx_add_arbiter
module tb_approx_add_arbiter;

    localparam int N   = 32;
    localparam int K   = 8;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [R-1:0]     req_valid;
    logic [R-1:0]     req_ready;
    logic [R*N-1:0]   req_a;
    logic [R*N-1:0]   req_b;
    logic [R-1:0]     req_approx;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_sum;
    logic [IDW-1:0]   res_id;
    logic             res_dropped;
    logic             drop_clr;
    logic [15:0]      drop_count;

    int checks = 0;
    int errors = 0;

    approx_add_arbiter #(.N(N), .K(K), .R(R), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_approx(req_approx),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id), .res_dropped(res_dropped),
        .drop_clr(drop_clr), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic ap);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_approx[i]   = ap;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b1; drop_clr = 1'b0;
        req_a = '0; req_b = '0; req_approx = '0;
        step(); step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b expected 0000", req_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b expected 0", res_valid); end
        checks++; if (res_sum !== 32'h0) begin errors++; $display("FAIL reset_res_sum got %h expected 0", res_sum); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got %0d expected 0", res_id); end
        checks++; if (res_dropped !== 1'b0) begin errors++; $display("FAIL reset_res_dropped got %b expected 0", res_dropped); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count got %h expected 0", drop_count); end
        req_valid = 4'h0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exact();
        set_op(2, 32'h000000FF, 32'h00000001, 1'b0);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL exact_grant got %b expected 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL exact_valid got %b expected 1", res_valid); end
        checks++; if (res_sum !== 32'h00000100) begin errors++; $display("FAIL exact_sum got %h expected 00000100", res_sum); end
        checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL exact_id got %0d expected 2", res_id); end
        checks++; if (res_dropped !== 1'b0) begin errors++; $display("FAIL exact_dropped got %b expected 0", res_dropped); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL exact_drop_count got %0d expected 0", drop_count); end
    endtask

    task automatic test_approx();
        set_op(2, 32'h000000FF, 32'h00000001, 1'b1);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        checks++; if (res_sum !== 32'h00000000) begin errors++; $display("FAIL approx1_sum got %h expected 00000000", res_sum); end
        checks++; if (res_dropped !== 1'b1) begin errors++; $display("FAIL approx1_dropped got %b expected 1", res_dropped); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL approx1_drop_count got %0d expected 1", drop_count); end
        set_op(2, 32'h12345680, 32'h00010080, 1'b1);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        checks++; if (res_sum !== 32'h12355600) begin errors++; $display("FAIL approx2_sum got %h expected 12355600", res_sum); end
        checks++; if (res_dropped !== 1'b1) begin errors++; $display("FAIL approx2_dropped got %b expected 1", res_dropped); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL approx2_drop_count got %0d expected 2", drop_count); end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL approx_drain got %b expected 0", res_valid); end
    endtask

    task automatic test_round_robin();
        int exp_a[8];
        int exp_b[4];
        exp_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_b = '{0, 2, 3, 0};
        for (int i = 0; i < R; i++) set_op(i, N'(i * 16 + 1), 32'h0, 1'b0);
        // Pointer sits at 3 after the last grant to 2; a lone grant to 3 wraps it to 0.
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if ($countones(req_ready) != 1 || req_ready !== (4'b0001 << exp_a[c])) begin
                errors++; $display("FAIL rr_ready[%0d] got %b expected one-hot bit %0d", c, req_ready, exp_a[c]);
            end
            step();
            checks++;
            if (res_id !== IDW'(exp_a[c]) || res_sum !== N'(exp_a[c] * 16 + 1)) begin
                errors++; $display("FAIL rr_id[%0d] got id %0d sum %h expected id %0d", c, res_id, res_sum, exp_a[c]);
            end
        end
        req_valid = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (res_id !== IDW'(exp_b[c])) begin
                errors++; $display("FAIL rr_skip_id[%0d] got %0d expected %0d", c, res_id, exp_b[c]);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        set_op(0, 32'd5, 32'd6, 1'b0);
        set_op(1, 32'd7, 32'd8, 1'b0);
        req_valid = 4'b0001;
        step();
        checks++; if (res_valid !== 1'b1 || res_sum !== 32'd11 || res_id !== 2'd0) begin
            errors++; $display("FAIL bp_first got valid %b sum %0d id %0d expected 1 11 0", res_valid, res_sum, res_id);
        end
        res_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b expected 0000", c, req_ready); end
            step();
            checks++;
            if (res_valid !== 1'b1 || res_sum !== 32'd11 || res_id !== 2'd0 || res_dropped !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got valid %b sum %0d id %0d dropped %b expected 1 11 0 0", c, res_valid, res_sum, res_id, res_dropped);
            end
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 32'd15 || res_id !== 2'd1) begin
            errors++; $display("FAIL bp_back_to_back got valid %b sum %0d id %0d expected 1 15 1", res_valid, res_sum, res_id);
        end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b expected 0", res_valid); end
    endtask

    task automatic test_counter();
        set_op(0, 32'h000000FF, 32'h00000001, 1'b1);
        req_valid = 4'b0001;
        for (int c = 0; c < 65540; c++) step();
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got %h expected ffff", drop_count); end
        step(); step();
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold got %h expected ffff", drop_count); end
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL cnt_clr_priority got %h expected 0", drop_count); end
        step();
        req_valid = 4'b0000;
        checks++; if (drop_count !== 16'h1) begin errors++; $display("FAIL cnt_after_clr got %h expected 1", drop_count); end
        step();
    endtask

    task automatic test_reset_mid();
        set_op(1, 32'd1, 32'd2, 1'b0);
        res_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin errors++; $display("FAIL rst_mid_setup got valid %b id %0d expected 1 1", res_valid, res_id); end
        rst_n = 1'b0;
        step();
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 32'h0 || res_id !== 2'd0 || res_dropped !== 1'b0 || drop_count !== 16'h0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_values got valid %b sum %h id %0d dropped %b cnt %h ready %b expected all zero", res_valid, res_sum, res_id, res_dropped, drop_count, req_ready);
        end
        rst_n = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_first_grant got %b expected 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin errors++; $display("FAIL rst_mid_first_result got valid %b id %0d expected 1 0", res_valid, res_id); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_round_robin();
        test_backpressure();
        test_counter();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
